cmp_share_arbiter: RTL and testbench

//  Lets NREQ requesters share one unsigned WIDTH-bit magnitude comparator (nbitcomparator).
//  - Round-robin arbitration picks one requester.
//  - The winner's operands are latched and compared.
//  - Registered gt/eq/lt flags are returned with a one-cycle done strobe.

---
 rtl/cmp_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// Shares one unsigned magnitude comparator between NREQ requesters under round-robin arbitration.
// Latency: grant one edge after req is sampled, done/results on the next edge, then one idle cycle.
// Backpressure: requesters hold req until done; one compare in flight, at most one per 3 cycles.
module nbitcomparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

module cmp_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_bus,
    input  logic [NREQ*WIDTH-1:0] b_bus,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  res_gt,
    output logic                  res_eq,
    output logic                  res_lt,
    output logic                  busy
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   last_grant;
    logic [IDXW-1:0]   winner;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;

    logic              found;
    logic [IDXW-1:0]   pick;
    logic [IDXW-1:0]   cand;
    int                rr_idx;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic              cmp_gt;
    logic              cmp_eq;
    logic              cmp_lt;

    // Search starts just after the last served requester and wraps modulo NREQ.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        cand   = '0;
        rr_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = int'(last_grant) + k;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            cand = IDXW'(rr_idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IDXW'(i)) begin
                a_sel = a_bus[i*WIDTH +: WIDTH];
                b_sel = b_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    nbitcomparator #(.WIDTH(WIDTH)) u_cmp (
        .a  (op_a),
        .b  (op_b),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            done       <= '0;
            res_gt     <= 1'b0;
            res_eq     <= 1'b0;
            res_lt     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            winner     <= '0;
            last_grant <= IDXW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner <= pick;
                        gnt    <= ONE << pick;
                        op_a   <= a_sel;
                        op_b   <= b_sel;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    res_gt <= cmp_gt;
                    res_eq <= cmp_eq;
                    res_lt <= cmp_lt;
                    done   <= ONE << winner;
                    state  <= RESP;
                end
                RESP: begin
                    done       <= '0;
                    gnt        <= '0;
                    last_grant <= winner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed and randomized bench for cmp_share_arbiter against a transaction-level model.
module tb_cmp_share_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 2;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] a_bus = '0;
    logic [NREQ*WIDTH-1:0] b_bus = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  res_gt;
    logic                  res_eq;
    logic                  res_lt;
    logic                  busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    cmp_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a_bus  (a_bus),
        .b_bus  (b_bus),
        .gnt    (gnt),
        .done   (done),
        .res_gt (res_gt),
        .res_eq (res_eq),
        .res_lt (res_lt),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: remaining cycles of the current compare, served index, captured operands.
    int               m_left = 0;
    int               m_last = NREQ - 1;
    int               m_win  = 0;
    logic             m_found;
    logic [WIDTH-1:0] m_a, m_b;
    logic [NREQ-1:0]  m_gnt  = '0;
    logic [NREQ-1:0]  m_done = '0;
    logic             m_gt = 1'b0, m_eq = 1'b0, m_lt = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_last = NREQ - 1; m_gnt = '0; m_done = '0;
            m_gt = 1'b0; m_eq = 1'b0; m_lt = 1'b0;
        end else if (m_left == 0) begin
            if (req != '0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!m_found && req[(m_last + k) % NREQ]) begin
                        m_found = 1'b1;
                        m_win = (m_last + k) % NREQ;
                    end
                end
                m_a = a_bus[m_win*WIDTH +: WIDTH];
                m_b = b_bus[m_win*WIDTH +: WIDTH];
                m_gnt = NREQ'(1 << m_win);
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_done = NREQ'(1 << m_win);
            m_gt = (m_a > m_b); m_eq = (m_a == m_b); m_lt = (m_a < m_b);
            m_left = 1;
        end else begin
            m_done = '0; m_gnt = '0; m_last = m_win; m_left = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt), 32'(m_gnt));
            check("done", 32'(done), 32'(m_done));
            check("res_gt", 32'(res_gt), 32'(m_gt));
            check("res_eq", 32'(res_eq), 32'(m_eq));
            check("res_lt", 32'(res_lt), 32'(m_lt));
            check("busy", 32'(busy), 32'(m_left != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Single-requester compare; a_late overwrites A while the compare is in LOAD.
    task automatic txn(input int who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] a_late, input logic [2:0] exp_res);
        req = NREQ'(1 << who);
        a_bus[who*WIDTH +: WIDTH] = a;
        b_bus[who*WIDTH +: WIDTH] = b;
        tick();
        check($sformatf("txn%0d_gnt", who), 32'(gnt), 32'(1 << who));
        check($sformatf("txn%0d_done_early", who), 32'(done), 32'd0);
        a_bus[who*WIDTH +: WIDTH] = a_late;
        tick();
        check($sformatf("txn%0d_done", who), 32'(done), 32'(1 << who));
        check($sformatf("txn%0d_res", who), 32'({res_gt, res_eq, res_lt}), 32'(exp_res));
        req = '0;
        tick();
        check($sformatf("txn%0d_release", who), 32'({gnt, done, busy}), 32'd0);
    endtask

    int rot_gnt [12] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
    int rot_done[12] = '{0, 1, 0, 0, 2, 0, 0, 1, 0, 0, 2, 0};
    int rot_busy[12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    int rot_res [12] = '{0, 1, 1, 1, 2, 2, 2, 1, 1, 1, 2, 2};

    initial begin
        // Reset must clear outputs before any clock edge.
        req = NREQ'($urandom); a_bus = $urandom; b_bus = $urandom;
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'({res_gt, res_eq, res_lt}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req = '0;
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        txn(0, 4'b1110, 4'b1110, 4'b1110, 3'b010);
        txn(1, 4'b0011, 4'b0010, 4'b0000, 3'b100);

        // Continuous requests from both sides rotate strictly.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 2'b11;
        a_bus = {4'b0101, 4'b1001};
        b_bus = {4'b0101, 4'b1100};
        for (int t = 0; t < 12; t++) begin
            tick();
            check($sformatf("rot_gnt[%0d]", t), 32'(gnt), 32'(rot_gnt[t]));
            check($sformatf("rot_done[%0d]", t), 32'(done), 32'(rot_done[t]));
            check($sformatf("rot_busy[%0d]", t), 32'(busy), 32'(rot_busy[t]));
            check($sformatf("rot_res[%0d]", t), 32'({res_gt, res_eq, res_lt}), 32'(rot_res[t]));
        end
        req = '0;
        tick();

        // Request withdrawn during LOAD still completes exactly once.
        req = 2'b01;
        a_bus[3:0] = 4'b1001; b_bus[3:0] = 4'b1100;
        tick();
        check("wd_gnt", 32'(gnt), 32'd1);
        req = '0;
        tick();
        check("wd_done", 32'(done), 32'd1);
        check("wd_res", 32'({res_gt, res_eq, res_lt}), 32'b001);
        tick();
        tick();
        check("wd_no_regrant", 32'({gnt, busy}), 32'd0);

        txn(0, 4'b1111, 4'b0000, 4'b1111, 3'b100);
        txn(1, 4'b0000, 4'b1111, 4'b0000, 3'b001);
        txn(0, 4'b0000, 4'b0000, 4'b0000, 3'b010);
        txn(1, 4'b1111, 4'b1111, 4'b1111, 3'b010);

        // Reset during LOAD aborts the compare with no done.
        req = 2'b10;
        tick();
        check("abort_gnt", 32'(gnt), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outs", 32'({gnt, done, busy, res_gt, res_eq, res_lt}), 32'd0);
        req = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_first_gnt", 32'(gnt), 32'd1);
        check("abort_no_done", 32'(done), 32'd0);
        req = '0;
        tick();
        tick();

        // Priority returns to requester 0 after reset even when 0 was last served.
        txn(0, 4'b0001, 4'b0010, 4'b0001, 3'b001);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 2'b11;
        tick();
        check("rst_prio_gnt", 32'(gnt), 32'd1);
        req = '0;
        tick();
        tick();

        for (int c = 0; c < 3000; c++) begin
            req   = NREQ'($urandom);
            a_bus = $urandom;
            b_bus = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        req = '0;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
